// File: rtl/instr_rom_access_if.sv
// Fetch-side request/response bundle for the instruction ROM port.
interface instr_rom_access_if #(
  parameter int EXC_LEN = 2
);
  logic [31:0]        addr_In;
  logic               inputValid_In;
  logic [31:0]        instr_Out;
  logic               outputValid_Out;
  logic [EXC_LEN-1:0] exception_Out;

  modport master (
    output addr_In,
    output inputValid_In,
    input  instr_Out,
    input  outputValid_Out,
    input  exception_Out
  );

  modport slave (
    input  addr_In,
    input  inputValid_In,
    output instr_Out,
    output outputValid_Out,
    output exception_Out
  );
endinterface

// File: rtl/instr_rom_access.sv
// Instruction ROM port: fixed-latency word read for fetch,
// with misaligned and out-of-range fault reporting.
module instr_rom_access #(
  parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
  parameter int          ROM_WORDS    = 4096,
  parameter int          READ_LATENCY = 2,
  parameter int          EXC_LEN      = 2,
  parameter logic [EXC_LEN-1:0] EXC_NONE     = EXC_LEN'(0),
  parameter logic [EXC_LEN-1:0] EXC_MISALIGN = EXC_LEN'(1),
  parameter logic [EXC_LEN-1:0] EXC_FAULT    = EXC_LEN'(2)
) (
  input logic               clk,
  input logic               rst,
  instr_rom_access_if.slave bus
);
  localparam int AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      idx_q;
  logic [31:0]        pend_q;
  logic [31:0]        held_q;
  logic [EXC_LEN-1:0] exc_q;

  // Contents come from the boot image; never reset.
  logic [31:0] rom [ROM_WORDS];

  logic [29:0]   word_off;
  logic [AW-1:0] word_idx;
  logic          misalign;
  logic          fault;
  logic          fire;

  assign word_off = bus.addr_In[31:2] - ROM_BASE[31:2];
  assign word_idx = word_off[AW-1:0];
  assign misalign = bus.addr_In[1:0] != 2'b00;
  assign fault    = (bus.addr_In < ROM_BASE) ||
                    ({2'b00, word_off} >= 32'(ROM_WORDS));

  assign fire = (state_q == RESP) && bus.inputValid_In;

  assign bus.outputValid_Out = fire;
  assign bus.instr_Out       = fire ? pend_q : held_q;
  assign bus.exception_Out   = fire ? exc_q : EXC_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= NOP;
      held_q  <= NOP;
      exc_q   <= EXC_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.inputValid_In) begin
            idx_q <= word_idx;
            if (misalign) begin
              pend_q  <= NOP;
              exc_q   <= EXC_MISALIGN;
              state_q <= RESP;
            end else if (fault) begin
              pend_q  <= NOP;
              exc_q   <= EXC_FAULT;
              state_q <= RESP;
            end else if (READ_LATENCY == 1) begin
              pend_q  <= rom[word_idx];
              exc_q   <= EXC_NONE;
              cnt_q   <= '0;
              state_q <= RESP;
            end else begin
              cnt_q   <= CW'(READ_LATENCY - 1);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.inputValid_In) begin
            state_q <= IDLE;
          end else if (cnt_q == CW'(1)) begin
            pend_q  <= rom[idx_q];
            exc_q   <= EXC_NONE;
            cnt_q   <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // An aborted response leaves the visible word untouched.
          if (bus.inputValid_In) held_q <= pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_rom_access.sv
// Bench for instr_rom_access: directed fetches plus random
// traffic checked every cycle against a transaction model.
module tb_instr_rom_access;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int W0 = 4096;
  localparam int W1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] d_addr [2];
  logic        d_v    [2];
  logic        o_v    [2];
  logic [31:0] o_i    [2];
  logic [1:0]  o_e    [2];

  logic [31:0] rom0 [W0];
  logic [31:0] rom1 [W1];

  int n_tests = 0;
  int n_fail  = 0;

  instr_rom_access_if #(.EXC_LEN(2)) bus0 ();
  instr_rom_access_if #(.EXC_LEN(2)) bus1 ();

  assign bus0.addr_In       = d_addr[0];
  assign bus0.inputValid_In = d_v[0];
  assign bus1.addr_In       = d_addr[1];
  assign bus1.inputValid_In = d_v[1];
  assign o_v[0] = bus0.outputValid_Out;
  assign o_i[0] = bus0.instr_Out;
  assign o_e[0] = bus0.exception_Out;
  assign o_v[1] = bus1.outputValid_Out;
  assign o_i[1] = bus1.instr_Out;
  assign o_e[1] = bus1.exception_Out;

  instr_rom_access #(
    .ROM_BASE(32'h0000_0000),
    .ROM_WORDS(W0),
    .READ_LATENCY(2)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  instr_rom_access #(
    .ROM_BASE(32'h0000_1000),
    .ROM_WORDS(W1),
    .READ_LATENCY(3)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int words_of(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [31:0] rom_rd(input int k, input int i);
    return (k == 0) ? rom0[i] : rom1[i];
  endfunction

  // What a request to address a should return, and how long it takes.
  task automatic classify(input int k, input logic [31:0] a,
                          output logic [31:0] r,
                          output logic [1:0] e,
                          output int l);
    logic [31:0] b;
    b = base_of(k);
    if (a[1:0] != 2'b00) begin
      r = NOP; e = 2'd1; l = 1;
    end else if (a < b || ((a - b) >> 2) >= 32'(words_of(k))) begin
      r = NOP; e = 2'd2; l = 1;
    end else begin
      r = rom_rd(k, int'((a - b) >> 2));
      e = 2'd0;
      l = lat_of(k);
    end
  endtask

  bit          m_pend [2];
  int          m_rem  [2];
  logic [31:0] m_res  [2];
  logic [1:0]  m_exc  [2];
  logic [31:0] m_held [2];

  task automatic step(input int k);
    logic        ev;
    logic [31:0] ei;
    logic [1:0]  ee;
    logic [31:0] r;
    logic [1:0]  e;
    int          l;
    if (rst) begin
      m_pend[k] = 1'b0;
      m_held[k] = NOP;
      return;
    end
    ev = 1'b0;
    if (m_pend[k]) begin
      m_rem[k]--;
      if (m_rem[k] == 0) begin
        m_pend[k] = 1'b0;
        ev = d_v[k];
      end else if (!d_v[k]) begin
        m_pend[k] = 1'b0;
      end
    end else if (d_v[k]) begin
      classify(k, d_addr[k], r, e, l);
      m_res[k]  = r;
      m_exc[k]  = e;
      m_rem[k]  = l;
      m_pend[k] = 1'b1;
    end
    ei = ev ? m_res[k] : m_held[k];
    ee = ev ? m_exc[k] : 2'd0;
    check($sformatf("d%0d_valid", k), 32'(o_v[k]), 32'(ev));
    check($sformatf("d%0d_instr", k), o_i[k], ei);
    check($sformatf("d%0d_exc", k), 32'(o_e[k]), 32'(ee));
    if (ev) m_held[k] = m_res[k];
  endtask

  always @(negedge clk) begin
    step(0);
    step(1);
  end

  // Fetch-style request: hold until served, drop one cycle, return.
  task automatic fetch(input int k, input logic [31:0] a,
                       input logic [31:0] exp_i,
                       input logic [1:0] exp_e,
                       input int exp_lat,
                       input bit toggle);
    int          cyc;
    bit          seen;
    logic [31:0] gi;
    logic [1:0]  ge;
    d_addr[k] = a;
    d_v[k]    = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    gi   = '0;
    ge   = '0;
    while (!seen && cyc < 16) begin
      @(negedge clk);
      if (o_v[k]) begin
        seen = 1'b1;
        gi = o_i[k];
        ge = o_e[k];
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        if (toggle && cyc == 1) d_addr[k] = a ^ 32'h20;
      end
    end
    check($sformatf("fetch%0d_%h_lat", k, a), 32'(cyc), 32'(exp_lat));
    check($sformatf("fetch%0d_%h_instr", k, a), gi, exp_i);
    check($sformatf("fetch%0d_%h_exc", k, a), 32'(ge), 32'(exp_e));
    @(posedge clk);
    #1;
    d_v[k] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input int k);
    logic [31:0] b;
    logic [31:0] top;
    b   = base_of(k);
    top = b + 32'(4 * words_of(k));
    case ($urandom_range(0, 7))
      0: return top - 32'd4;
      1: return top;
      2: return b - 32'd4;
      3: return top | 32'($urandom_range(1, 3));
      4: return $urandom;
      5: return b + 32'(4 * $urandom_range(0, words_of(k) - 1))
                  + 32'($urandom_range(1, 3));
      default: return b + 32'(4 * $urandom_range(0, words_of(k) - 1));
    endcase
  endfunction

  initial begin
    d_addr[0] = 32'h0;
    d_addr[1] = 32'h1000;
    d_v[0]    = 1'b0;
    d_v[1]    = 1'b0;
    for (int i = 0; i < W0; i++) begin
      rom0[i] = $urandom;
      u_dut0.rom[i] = rom0[i];
    end
    rom0[0] = 32'h0050_0093;
    u_dut0.rom[0] = rom0[0];
    for (int i = 0; i < W1; i++) begin
      rom1[i] = $urandom;
      u_dut1.rom[i] = rom1[i];
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    fetch(0, 32'h0000_0000, 32'h0050_0093, 2'd0, 2, 1'b0);
    fetch(0, 32'h0000_0004, rom0[1], 2'd0, 2, 1'b0);
    fetch(0, 32'h0000_0008, rom0[2], 2'd0, 2, 1'b0);
    fetch(0, 32'h0000_0002, NOP, 2'd1, 1, 1'b0);
    fetch(0, 32'h0000_4000, NOP, 2'd2, 1, 1'b0);
    fetch(0, 32'hFFFF_FFFC, NOP, 2'd2, 1, 1'b0);
    fetch(0, 32'h0000_3FFC, rom0[W0-1], 2'd0, 2, 1'b0);
    fetch(1, 32'h0000_0FFC, NOP, 2'd2, 1, 1'b0);
    fetch(1, 32'h0000_1040, NOP, 2'd2, 1, 1'b0);
    fetch(1, 32'h0000_1042, NOP, 2'd1, 1, 1'b0);
    fetch(1, 32'h0000_103C, rom1[W1-1], 2'd0, 3, 1'b1);

    // Abort in WAIT, then re-request with the address wiggled mid-read.
    d_addr[0] = 32'h20;
    d_v[0]    = 1'b1;
    @(posedge clk);
    #1;
    d_v[0] = 1'b0;
    @(posedge clk);
    #1;
    fetch(0, 32'h0000_0010, rom0[4], 2'd0, 2, 1'b1);

    d_addr[1] = 32'h1008;
    d_v[1]    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d_v[1] = 1'b0;
    @(posedge clk);
    #1;
    fetch(1, 32'h0000_1010, rom1[4], 2'd0, 3, 1'b0);

    // Reset while a read is in flight.
    d_addr[0] = 32'hC;
    d_v[0]    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    d_v[0] = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(o_v[0]), 32'd0);
    check("rst_instr", o_i[0], NOP);
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (d_v[k]) begin
          if ($urandom_range(0, 7) == 0) d_v[k] = 1'b0;
          else if ($urandom_range(0, 3) == 0) d_addr[k] = rand_addr(k);
        end else if ($urandom_range(0, 1) == 0) begin
          d_v[k]    = 1'b1;
          d_addr[k] = rand_addr(k);
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    rst    = 1'b0;
    d_v[0] = 1'b0;
    d_v[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
